// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel alarm controller.
package alarm_pkg;

   localparam int unsigned TIME_W_DEF  = 6;
   localparam int unsigned MAX_CH      = 8;
   localparam int unsigned MAX_FIELD_W = 8;
   localparam int unsigned PACK_W      = MAX_CH * MAX_FIELD_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZED = 2'd2
   } state_t;

   // Extract channel idx from a packed per-channel vector of w-bit fields.
   function automatic logic [MAX_FIELD_W-1:0] ch_field(input logic [PACK_W-1:0] vec,
                                                       input int unsigned       idx,
                                                       input int unsigned       w);
      return MAX_FIELD_W'(vec >> (idx * w));
   endfunction

endpackage

// File: rtl/alarm_match.sv
// Minute-edge detector plus per-channel time compare; hits pulse for one cycle per matching minute.
module alarm_match
   import alarm_pkg::*;
#(
   parameter int unsigned N_ALARMS = 4,
   parameter int unsigned TIME_W   = TIME_W_DEF
) (
   input  logic                       clk_1hz,
   input  logic                       reset_n,
   input  logic [TIME_W-1:0]          clockhour,
   input  logic [TIME_W-1:0]          clockminute,
   input  logic [N_ALARMS*TIME_W-1:0] alarmhour,
   input  logic [N_ALARMS*TIME_W-1:0] alarmminute,
   input  logic [N_ALARMS-1:0]        alarm_en,
   output logic [N_ALARMS-1:0]        hits_c
);

   logic [TIME_W-1:0] prev_minute;
   logic              primed;
   logic              tick_c;

   // primed keeps the first post-reset cycle from looking like a minute change
   always_ff @(posedge clk_1hz or negedge reset_n) begin
      if (!reset_n) begin
         prev_minute <= '0;
         primed      <= 1'b0;
      end else begin
         prev_minute <= clockminute;
         primed      <= 1'b1;
      end
   end

   assign tick_c = primed && (clockminute != prev_minute);

   always_comb begin
      hits_c = '0;
      for (int unsigned i = 0; i < N_ALARMS; i++) begin
         if (tick_c && alarm_en[i]
             && (clockhour   == TIME_W'(ch_field(PACK_W'(alarmhour),   i, TIME_W)))
             && (clockminute == TIME_W'(ch_field(PACK_W'(alarmminute), i, TIME_W))))
            hits_c[i] = 1'b1;
      end
   end

endmodule

// File: rtl/alarm_controller.sv
// Multi-channel alarm controller: queues matched channels and rings them one at a time with snooze and timeout.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int unsigned N_ALARMS         = 4,
   parameter int unsigned TIME_W           = TIME_W_DEF,
   parameter int unsigned SNOOZE_SEC       = 300,
   parameter int unsigned RING_TIMEOUT_SEC = 120,
   parameter int unsigned MAX_SNOOZE       = 3,
   localparam int unsigned CH_W            = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
   localparam int unsigned SC_W            = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
   input  logic                       clk_1hz,
   input  logic                       reset_n,
   input  logic [TIME_W-1:0]          clockhour,
   input  logic [TIME_W-1:0]          clockminute,
   input  logic [N_ALARMS*TIME_W-1:0] alarmhour,
   input  logic [N_ALARMS*TIME_W-1:0] alarmminute,
   input  logic [N_ALARMS-1:0]        alarm_en,
   input  logic                       snooze,
   input  logic                       dismiss,
   output logic                       alarmtrigger,
   output logic [CH_W-1:0]            active_ch,
   output logic                       snoozing,
   output logic [N_ALARMS-1:0]        pending,
   output logic [SC_W-1:0]            snooze_cnt
);

   localparam int unsigned TMR_MAX = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   state_t              state, state_nxt;
   logic [TMR_W-1:0]    timer, timer_nxt;
   logic [SC_W-1:0]     snooze_cnt_nxt;
   logic [CH_W-1:0]     active_ch_nxt;
   logic [N_ALARMS-1:0] pending_nxt;
   logic [N_ALARMS-1:0] hits_c;
   logic [N_ALARMS-1:0] eff_c;
   logic [CH_W-1:0]     first_ch_c;
   logic                active_en_c;

   alarm_match #(
      .N_ALARMS (N_ALARMS),
      .TIME_W   (TIME_W)
   ) u_match (
      .clk_1hz     (clk_1hz),
      .reset_n     (reset_n),
      .clockhour   (clockhour),
      .clockminute (clockminute),
      .alarmhour   (alarmhour),
      .alarmminute (alarmminute),
      .alarm_en    (alarm_en),
      .hits_c      (hits_c)
   );

   // Queued plus fresh hits, with disabled channels dropped; lowest index wins
   always_comb begin
      eff_c      = (pending | hits_c) & alarm_en;
      first_ch_c = '0;
      for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
         if (eff_c[i])
            first_ch_c = CH_W'(i);
      end
      active_en_c = alarm_en[active_ch];
   end

   // Next-state logic
   always_comb begin
      state_nxt      = state;
      timer_nxt      = timer;
      snooze_cnt_nxt = snooze_cnt;
      active_ch_nxt  = active_ch;
      pending_nxt    = eff_c;

      case (state)
         IDLE: begin
            if (eff_c != '0) begin
               state_nxt      = RINGING;
               active_ch_nxt  = first_ch_c;
               pending_nxt    = eff_c & ~(N_ALARMS'(1) << first_ch_c);
               timer_nxt      = '0;
               snooze_cnt_nxt = '0;
            end
         end
         RINGING: begin
            if (dismiss || !active_en_c) begin
               state_nxt     = IDLE;
               active_ch_nxt = '0;
               timer_nxt     = '0;
            end else if (snooze && (snooze_cnt < SC_W'(MAX_SNOOZE))) begin
               state_nxt      = SNOOZED;
               snooze_cnt_nxt = snooze_cnt + SC_W'(1);
               timer_nxt      = '0;
            end else if (timer == TMR_W'(RING_TIMEOUT_SEC - 1)) begin
               state_nxt     = IDLE;
               active_ch_nxt = '0;
               timer_nxt     = '0;
            end else begin
               timer_nxt = timer + TMR_W'(1);
            end
         end
         SNOOZED: begin
            if (dismiss || !active_en_c) begin
               state_nxt     = IDLE;
               active_ch_nxt = '0;
               timer_nxt     = '0;
            end else if (timer == TMR_W'(SNOOZE_SEC - 1)) begin
               state_nxt = RINGING;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TMR_W'(1);
            end
         end
         default: begin
            state_nxt     = IDLE;
            active_ch_nxt = '0;
            timer_nxt     = '0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk_1hz or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         timer        <= '0;
         snooze_cnt   <= '0;
         active_ch    <= '0;
         pending      <= '0;
         alarmtrigger <= 1'b0;
         snoozing     <= 1'b0;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         snooze_cnt   <= snooze_cnt_nxt;
         active_ch    <= active_ch_nxt;
         pending      <= pending_nxt;
         alarmtrigger <= (state_nxt == RINGING);
         snoozing     <= (state_nxt == SNOOZED);
      end
   end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: vector table for single-cycle behaviour, hand sequences for timers and reset.
module tb_alarm_controller;

   localparam int unsigned N  = 4;
   localparam int unsigned TW = 6;

   logic              clk_1hz = 1'b0;
   logic              reset_n;
   logic [TW-1:0]     clockhour, clockminute;
   logic [N*TW-1:0]   alarmhour, alarmminute;
   logic [N-1:0]      alarm_en;
   logic              snooze, dismiss;
   logic              alarmtrigger;
   logic [1:0]        active_ch;
   logic              snoozing;
   logic [N-1:0]      pending;
   logic [1:0]        snooze_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [TW-1:0] hour;
      logic [TW-1:0] minute;
      logic [N-1:0]  en;
      logic          sn;
      logic          dis;
      logic          trig;
      logic [1:0]    ch;
      logic          snz;
      logic [N-1:0]  pend;
      logic [1:0]    cnt;
   } vec_t;

   vec_t vecs[13];

   alarm_controller #(
      .N_ALARMS         (N),
      .TIME_W           (TW),
      .SNOOZE_SEC       (300),
      .RING_TIMEOUT_SEC (120),
      .MAX_SNOOZE       (3)
   ) dut (
      .clk_1hz      (clk_1hz),
      .reset_n      (reset_n),
      .clockhour    (clockhour),
      .clockminute  (clockminute),
      .alarmhour    (alarmhour),
      .alarmminute  (alarmminute),
      .alarm_en     (alarm_en),
      .snooze       (snooze),
      .dismiss      (dismiss),
      .alarmtrigger (alarmtrigger),
      .active_ch    (active_ch),
      .snoozing     (snoozing),
      .pending      (pending),
      .snooze_cnt   (snooze_cnt)
   );

   always #5 clk_1hz = ~clk_1hz;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_1hz);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic trig, input logic [1:0] ch,
                          input logic snz, input logic [N-1:0] pend, input logic [1:0] cnt);
      chk({tag, ".alarmtrigger"}, 32'(alarmtrigger), 32'(trig));
      chk({tag, ".active_ch"},    32'(active_ch),    32'(ch));
      chk({tag, ".snoozing"},     32'(snoozing),     32'(snz));
      chk({tag, ".pending"},      32'(pending),      32'(pend));
      chk({tag, ".snooze_cnt"},   32'(snooze_cnt),   32'(cnt));
   endtask

   task automatic apply_vec(input int i);
      clockhour   = vecs[i].hour;
      clockminute = vecs[i].minute;
      alarm_en    = vecs[i].en;
      snooze      = vecs[i].sn;
      dismiss     = vecs[i].dis;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].trig, vecs[i].ch, vecs[i].snz, vecs[i].pend, vecs[i].cnt);
   endtask

   task automatic pulse_snooze();
      snooze = 1'b1;
      step();
      snooze = 1'b0;
   endtask

   initial begin
      // hour, min, en, snooze, dismiss | trig, ch, snoozing, pending, cnt
      vecs[0]  = '{6'd7,  6'd29, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0};
      vecs[1]  = '{6'd7,  6'd30, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 2'd0};
      vecs[2]  = '{6'd7,  6'd30, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 2'd0};
      vecs[3]  = '{6'd7,  6'd30, 4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0};
      vecs[4]  = '{6'd7,  6'd30, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0};
      vecs[5]  = '{6'd5,  6'd59, 4'b0111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0};
      vecs[6]  = '{6'd6,  6'd0,  4'b0111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0100, 2'd0};
      vecs[7]  = '{6'd6,  6'd0,  4'b0111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0100, 2'd0};
      vecs[8]  = '{6'd6,  6'd0,  4'b0111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0100, 2'd0};
      vecs[9]  = '{6'd6,  6'd0,  4'b0111, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000, 2'd0};
      vecs[10] = '{6'd6,  6'd0,  4'b0111, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000, 2'd1};
      vecs[11] = '{6'd6,  6'd0,  4'b0111, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000, 2'd1};
      vecs[12] = '{6'd6,  6'd0,  4'b0011, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd1};

      // ch0 06:00, ch1 07:30, ch2 06:00, ch3 23:59
      alarmhour   = {6'd23, 6'd6, 6'd7,  6'd6};
      alarmminute = {6'd59, 6'd0, 6'd30, 6'd0};
      clockhour   = 6'd7;
      clockminute = 6'd29;
      alarm_en    = 4'b0010;
      snooze      = 1'b0;
      dismiss     = 1'b0;
      reset_n     = 1'b0;

      #2;
      chk_all("reset", 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0);
      step();
      step();
      reset_n = 1'b1;

      // Single alarm fires on the minute edge, dismiss, then no retrigger within the minute
      for (int i = 0; i <= 4; i++) apply_vec(i);
      for (int k = 0; k < 60; k++) begin
         step();
         chk("no_retrigger", 32'(alarmtrigger), 32'd0);
      end

      // Two channels on the same minute, queueing, snooze-ignore, disable mid-snooze
      for (int i = 5; i <= 12; i++) apply_vec(i);

      // Snooze cycles: exact re-ring latency and snooze limit
      alarm_en    = 4'b0010;
      clockhour   = 6'd7;
      clockminute = 6'd29;
      step();
      chk("pre_snooze_idle", 32'(alarmtrigger), 32'd0);
      clockminute = 6'd30;
      step();
      chk_all("snz_ring", 1'b1, 2'd1, 1'b0, 4'b0000, 2'd0);
      for (int k = 1; k <= 3; k++) begin
         pulse_snooze();
         chk_all($sformatf("snz%0d_enter", k), 1'b0, 2'd1, 1'b1, 4'b0000, 2'(k));
         repeat (299) step();
         chk($sformatf("snz%0d_still", k), 32'(snoozing), 32'd1);
         step();
         chk_all($sformatf("snz%0d_rering", k), 1'b1, 2'd1, 1'b0, 4'b0000, 2'(k));
      end
      pulse_snooze();
      chk_all("snz4_ignored", 1'b1, 2'd1, 1'b0, 4'b0000, 2'd3);
      dismiss = 1'b1;
      step();
      dismiss = 1'b0;
      chk("snz_dismiss", 32'(alarmtrigger), 32'd0);

      // Auto-dismiss after the ring timeout
      clockminute = 6'd31;
      step();
      clockminute = 6'd30;
      step();
      chk_all("to_ring", 1'b1, 2'd1, 1'b0, 4'b0000, 2'd0);
      repeat (119) step();
      chk("to_still_ringing", 32'(alarmtrigger), 32'd1);
      step();
      chk_all("to_dismissed", 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0);

      // Snooze and dismiss together: dismiss wins
      clockminute = 6'd31;
      step();
      clockminute = 6'd30;
      step();
      chk("sd_ring", 32'(alarmtrigger), 32'd1);
      snooze  = 1'b1;
      dismiss = 1'b1;
      step();
      snooze  = 1'b0;
      dismiss = 1'b0;
      chk_all("sd_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0);

      // Reset mid-ring with a queued channel, then no trigger on release at alarm time
      alarm_en    = 4'b0111;
      clockhour   = 6'd5;
      clockminute = 6'd59;
      step();
      clockhour   = 6'd6;
      clockminute = 6'd0;
      step();
      chk_all("rst_pre", 1'b1, 2'd0, 1'b0, 4'b0100, 2'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all("rst_async", 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0);
      step();
      reset_n = 1'b1;
      step();
      chk_all("rst_rel1", 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0);
      step();
      chk_all("rst_rel2", 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
